// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 host blocks.
package ps2_pkg;

  // Host-to-device transmit frame sequencing.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_ACK,
    ST_WAIT_IDLE
  } state_e;

  // Outcome of the most recent frame, held until the next acceptance.
  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_NO_ACK  = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

  // Converts a duration in microseconds into system clock cycles.
  function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
    return (clk_hz / 32'd1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: 2-flop synchroniser, FILTER_LEN consecutive-sample
// glitch filter and falling-edge detector. Shared by host TX and future RX.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic ps2c_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN);

  if (FILTER_LEN < 2 || FILTER_LEN > 32) begin : g_len_check
    $error("FILTER_LEN must be in the range 2..32");
  end

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic             filt_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchroniser, filter state and edge history.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would chain sync1 into sync2 in one cycle.
  // The synchroniser resets to 1 to match an idle, pulled-up bus line.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
    end else begin
      sync1_q     <= ps2c_i;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      cnt_q       <= cnt_d;
    end
  end

  // Count consecutive samples disagreeing with the filtered level; flip on the
  // FILTER_LEN-th one, restart the run whenever a sample agrees.
  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign filt_o = filt_q;
  assign fall_o = filt_prev_q & ~filt_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send, start/data/parity/
// stop bits clocked by the device, ACK check and inter-edge timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned RTS_US     = 100,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT_US = 15000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_ready_o,
  inout  wire        ps2c_io,
  inout  wire        ps2d_io,
  output logic       done_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned RTS_CYCLES     = us_to_cycles(CLK_HZ, RTS_US);
  localparam int unsigned TIMEOUT_CYCLES = us_to_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned RTS_W          = $clog2(RTS_CYCLES);
  localparam int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

  if (RTS_US < 100) begin : g_rts_check
    $error("RTS_US must be at least 100");
  end

  state_e           state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             parity_q, parity_d;
  logic [2:0]       bit_q, bit_d;
  logic [RTS_W-1:0] rts_q, rts_d;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  err_code_e        err_code_q, err_code_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             d_sync1_q, d_sync2_q;
  logic             filt, fall;
  logic             active, tmo_expired;

  // Open-drain pads: only ever pull low or float.
  assign ps2c_io = clk_oe_q  ? 1'b0 : 1'bz;
  assign ps2d_io = data_oe_q ? 1'b0 : 1'bz;

  ps2_clk_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .ps2c_i  (ps2c_io),
    .filt_o  (filt),
    .fall_o  (fall)
  );

  // Frame state, datapath and registered line drivers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      parity_q   <= 1'b0;
      bit_q      <= '0;
      rts_q      <= '0;
      tmo_q      <= '0;
      err_code_q <= ERR_NONE;
      clk_oe_q   <= 1'b0;
      data_oe_q  <= 1'b0;
      d_sync1_q  <= 1'b1;
      d_sync2_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      parity_q   <= parity_d;
      bit_q      <= bit_d;
      rts_q      <= rts_d;
      tmo_q      <= tmo_d;
      err_code_q <= err_code_d;
      clk_oe_q   <= clk_oe_d;
      data_oe_q  <= data_oe_d;
      d_sync1_q  <= ps2d_io;
      d_sync2_q  <= d_sync1_q;
    end
  end

  assign active      = (state_q != ST_IDLE) && (state_q != ST_RTS);
  assign tmo_inc     = tmo_q + 1'b1;
  // A device edge in the same cycle as expiry counts as the edge arriving.
  assign tmo_expired = active && !fall && (tmo_inc == TMO_W'(TIMEOUT_CYCLES));

  // Next-state, pulse outputs and line drive enables derived from next state
  // so the drivers are glitch-free flops that change together.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    parity_d   = parity_q;
    bit_d      = bit_q;
    rts_d      = rts_q;
    tmo_d      = fall ? '0 : tmo_inc;
    err_code_d = err_code_q;
    done_o     = 1'b0;
    err_o      = 1'b0;

    if (tmo_expired) begin
      err_o      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          tmo_d = '0;
          if (tx_valid_i) begin
            data_d     = tx_data_i;
            parity_d   = ~^tx_data_i;
            err_code_d = ERR_NONE;
            rts_d      = '0;
            state_d    = ST_RTS;
          end
        end
        ST_RTS: begin
          tmo_d = '0;
          if (rts_q == RTS_W'(RTS_CYCLES - 1)) begin
            state_d = ST_START;
          end else begin
            rts_d = rts_q + 1'b1;
          end
        end
        ST_START: begin
          if (fall) begin
            bit_d   = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (fall) begin
            if (bit_q == 3'd7) begin
              state_d = ST_PARITY;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (fall) state_d = ST_STOP;
        end
        ST_STOP: begin
          if (fall) state_d = ST_ACK;
        end
        ST_ACK: begin
          if (fall) begin
            if (!d_sync2_q) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              err_o      = 1'b1;
              err_code_d = ERR_NO_ACK;
              state_d    = ST_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (filt && d_sync2_q) begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    clk_oe_d = (state_d == ST_RTS);
    unique case (state_d)
      ST_START:  data_oe_d = 1'b1;
      ST_DATA:   data_oe_d = ~data_q[bit_d];
      ST_PARITY: data_oe_d = ~parity_q;
      default:   data_oe_d = 1'b0;
    endcase
  end

  assign tx_ready_o = (state_q == ST_IDLE);
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

  localparam int unsigned CLK_HZ     = 1_000_000;
  localparam int unsigned RTS_US     = 100;
  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT_US = 2000;

  localparam int RTS_CYC  = 100;
  localparam int TMO_CYC  = 2000;
  // Device clock drive to internal fall pulse: 2 sync flops + FILTER_LEN samples.
  localparam int FALL_LAT = FILTER_LEN + 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  wire        tx_ready;
  wire        done;
  wire        err;
  wire  [1:0] err_code;
  wire        ps2c;
  wire        ps2d;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .CLK_HZ     (CLK_HZ),
    .RTS_US     (RTS_US),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT_US (TIMEOUT_US)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .tx_valid_i (tx_valid),
    .tx_data_i  (tx_data),
    .tx_ready_o (tx_ready),
    .ps2c_io    (ps2c),
    .ps2d_io    (ps2d),
    .done_o     (done),
    .err_o      (err),
    .err_code_o (err_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int err_cyc = 0;
  int last_fall_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (done) done_cnt = done_cnt + 1;
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (done && err) both_cnt = both_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Request a byte, verify the RTS pulse and start bit, then clock n_falls
  // device edges. bits[7:0] data, bits[8] parity, bits[9] stop as sampled.
  task automatic run_frame(input string tag, input logic [7:0] data, input int n_falls,
                           input bit ack, input int glitch_fall, output logic [9:0] bits);
    int guard;
    int rts_len;
    bits = '1;
    @(negedge clk);
    tx_data  = data;
    tx_valid = 1'b1;
    guard = 0;
    while (!tx_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rts_len = 0;
    while (ps2c == 1'b0 && rts_len < 1000) begin
      rts_len++;
      @(negedge clk);
    end
    check({tag, " rts_len"}, rts_len, RTS_CYC);
    repeat (30) @(negedge clk);
    check({tag, " start_bit"}, {31'd0, ps2d}, 0);
    for (int i = 1; i <= n_falls; i++) begin
      if (i == 11 && ack) dev_d_low = 1'b1;
      dev_c_low     = 1'b1;
      last_fall_cyc = cyc;
      repeat (20) @(negedge clk);
      dev_c_low = 1'b0;
      if (i == 12) dev_d_low = 1'b0;
      if (i == glitch_fall) begin
        repeat (6) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (2) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (12) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      if (i <= 10) bits[i-1] = ps2d;
    end
  endtask

  // Full acknowledged frame with hand-computed parity.
  task automatic good_frame(input string tag, input logic [7:0] data, input logic par,
                            input int glitch_fall);
    logic [9:0] bits;
    run_frame(tag, data, 12, 1'b1, glitch_fall, bits);
    check({tag, " data"}, {24'd0, bits[7:0]}, {24'd0, data});
    check({tag, " parity"}, {31'd0, bits[8]}, {31'd0, par});
    check({tag, " stop"}, {31'd0, bits[9]}, 1);
    check({tag, " ready"}, {31'd0, tx_ready}, 1);
  endtask

  initial begin
    logic [9:0] bits;
    int guard;
    int d_before;
    int e_before;

    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst ready", {31'd0, tx_ready}, 1);
    check("rst done", {31'd0, done}, 0);
    check("rst err", {31'd0, err}, 0);
    check("rst err_code", {30'd0, err_code}, 0);
    check("rst ps2c", {31'd0, ps2c}, 1);
    check("rst ps2d", {31'd0, ps2d}, 1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    good_frame("f4", 8'hF4, 1'b0, 0);
    check("f4 done_cnt", done_cnt, 1);
    check("f4 err_cnt", err_cnt, 0);
    check("f4 err_code", {30'd0, err_code}, 0);

    good_frame("00", 8'h00, 1'b1, 0);
    good_frame("ff", 8'hFF, 1'b1, 0);
    check("00ff done_cnt", done_cnt, 3);

    run_frame("nak", 8'h5A, 12, 1'b0, 0, bits);
    check("nak data", {24'd0, bits[7:0]}, 32'h5A);
    check("nak err_cnt", err_cnt, 1);
    check("nak err_code", {30'd0, err_code}, 1);
    check("nak ready", {31'd0, tx_ready}, 1);
    check("nak done_cnt", done_cnt, 3);

    // Device goes silent after bit 3; bit 3 of 0x07 is 0 so the host is
    // actively pulling data low when the timeout fires.
    run_frame("tmo", 8'h07, 4, 1'b0, 0, bits);
    check("tmo bits", {28'd0, bits[3:0]}, 32'h7);
    check("tmo ps2d_held", {31'd0, ps2d}, 0);
    guard = 0;
    while (err_cnt == 1 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("tmo err_cnt", err_cnt, 2);
    check("tmo delay", err_cyc - last_fall_cyc, FALL_LAT + TMO_CYC);
    check("tmo err_code", {30'd0, err_code}, 2);
    check("tmo ps2c", {31'd0, ps2c}, 1);
    check("tmo ps2d", {31'd0, ps2d}, 1);
    check("tmo ready", {31'd0, tx_ready}, 1);

    good_frame("glitch", 8'hA5, 1'b1, 3);
    check("glitch done_cnt", done_cnt, 4);
    check("glitch err_code", {30'd0, err_code}, 0);

    run_frame("rst", 8'h00, 3, 1'b0, 0, bits);
    check("rst mid ps2d_low", {31'd0, ps2d}, 0);
    d_before = done_cnt;
    e_before = err_cnt;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst mid ps2d", {31'd0, ps2d}, 1);
    check("rst mid ps2c", {31'd0, ps2c}, 1);
    check("rst mid ready", {31'd0, tx_ready}, 1);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("rst mid done_cnt", done_cnt, d_before);
    check("rst mid err_cnt", err_cnt, e_before);

    good_frame("aa", 8'hAA, 1'b1, 0);
    check("aa done_cnt", done_cnt, 5);
    check("aa err_cnt", err_cnt, 2);
    check("both_high", both_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
